// File: rtl/ethpipe_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ethpipe_pkg
//  Description : Shared constants for the ethpipe RX slot scheduler. It holds
//                the default ring geometry, the slot-index width helper and
//                the encoding of the interrupt coalescing state machine.
//  Contents    : SLOT_NUM_DEFAULT, LEN_W_DEFAULT, idx_w(),
//                IRQ_ST_W / IRQ_IDLE / IRQ_WAIT / IRQ_FIRE
//  Revision    : 1.0  initial release
// ============================================================================
package ethpipe_pkg;

   localparam int SLOT_NUM_DEFAULT = 4;
   localparam int LEN_W_DEFAULT    = 16;

   // Interrupt coalescing FSM encoding
   localparam int         IRQ_ST_W = 2;
   localparam logic [1:0] IRQ_IDLE = 2'd0;
   localparam logic [1:0] IRQ_WAIT = 2'd1;
   localparam logic [1:0] IRQ_FIRE = 2'd2;

   // Width of an index into a table of 'n' entries; never below one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rx_slot_len_ram.sv
`default_nettype none
// ============================================================================
//  Module      : rx_slot_len_ram
//  Description : DEPTH x WIDTH register file holding the byte length of each
//                ring slot. One write port, one registered read port. A write
//                and a read of the same entry in the same cycle returns the
//                new write data, so a freshly written slot is readable on the
//                very next cycle.
//  Ports       : clk      in   clock
//                i_we     in   write enable
//                i_waddr  in   write address
//                i_wdata  in   write data
//                i_raddr  in   read address (sampled every cycle)
//                o_rdata  out  registered read data
//  Revision    : 1.0  initial release
// ============================================================================
module rx_slot_len_ram
   import ethpipe_pkg::*;
#(
   parameter int DEPTH = SLOT_NUM_DEFAULT,
   parameter int WIDTH = LEN_W_DEFAULT
) (
   input  logic                      clk,
   input  logic                      i_we,
   input  logic [idx_w(DEPTH)-1:0]   i_waddr,
   input  logic [WIDTH-1:0]          i_wdata,
   input  logic [idx_w(DEPTH)-1:0]   i_raddr,
   output logic [WIDTH-1:0]          o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Contents are intentionally not reset; the owner qualifies the read data.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/rx_slot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rx_slot_ctrl
//  Description : Ring scheduler for the RX frame slot buffer. Owns the write
//                index, read index and occupancy of SLOT_NUM slots, records
//                each frame length, presents the oldest frame to the host,
//                counts frames dropped on overflow and raises an interrupt.
//  Build macro : RX_IRQ_COALESCE_EN - when defined, irq is produced by a
//                threshold/timeout coalescing FSM; otherwise irq is high
//                whenever any frame is pending.
//  Ports       : sys_clk        in   clock (pci_clk domain)
//                sys_rst_n      in   synchronous active-low reset
//                frame_done     in   pulse: frame written into slot_wr_idx
//                frame_len      in   frame byte length, valid with frame_done
//                host_release   in   pulse: host consumed slot_rd_idx
//                rx_empty       out  a free slot exists at slot_wr_idx
//                slot_wr_idx    out  slot owned by the RX writer
//                slot_rd_idx    out  oldest filled slot
//                rd_valid       out  slot_rd_idx holds an unreleased frame
//                rd_len         out  length of frame at slot_rd_idx (0 if none)
//                pending_cnt    out  filled, unreleased slot count
//                drop_cnt       out  saturating count of dropped frames
//                err_underflow  out  sticky: release seen with ring empty
//                irq            out  level interrupt
//  Revision    : 1.0  initial release
// ============================================================================
module rx_slot_ctrl
   import ethpipe_pkg::*;
#(
   parameter int SLOT_NUM    = SLOT_NUM_DEFAULT,
   parameter int LEN_W       = LEN_W_DEFAULT,
   parameter int IRQ_THRESH  = 2,
   parameter int IRQ_TIMEOUT = 1024
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst_n,
   input  logic                       frame_done,
   input  logic [LEN_W-1:0]           frame_len,
   input  logic                       host_release,
   output logic                       rx_empty,
   output logic [idx_w(SLOT_NUM)-1:0] slot_wr_idx,
   output logic [idx_w(SLOT_NUM)-1:0] slot_rd_idx,
   output logic                       rd_valid,
   output logic [LEN_W-1:0]           rd_len,
   output logic [idx_w(SLOT_NUM):0]   pending_cnt,
   output logic [31:0]                drop_cnt,
   output logic                       err_underflow,
   output logic                       irq
);

   localparam int               IDX_W     = idx_w(SLOT_NUM);
   localparam int               CNT_W     = IDX_W + 1;
   localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(SLOT_NUM);
   localparam logic [IDX_W-1:0] C_IDX_ONE = IDX_W'(1);

   // Named marker scopes: an illegal configuration appears in the elaborated
   // hierarchy under these names.
   if ((SLOT_NUM < 2) || (SLOT_NUM > 16) || ((SLOT_NUM & (SLOT_NUM - 1)) != 0)) begin : g_bad_slot_num
   end
   if ((IRQ_THRESH < 1) || (IRQ_TIMEOUT < 1)) begin : g_bad_irq_cfg
   end

   logic [IDX_W-1:0] r_wr_ptr;
   logic [IDX_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_drop_cnt;
   logic             r_err_uf;

   logic             w_full;
   logic             w_empty;
   logic             w_wr_acc;
   logic             w_drop;
   logic             w_rel_ok;
   logic             w_rel_uf;
   logic [IDX_W-1:0] w_rd_ptr_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [LEN_W-1:0] w_rd_data;

   // Both pulses are judged against the pre-edge occupancy, which gives the
   // drop-and-release (full) and accept-and-underflow (empty) corner cases.
   assign w_full   = (r_cnt == C_FULL);
   assign w_empty  = (r_cnt == '0);
   assign w_wr_acc = frame_done & ~w_full;
   assign w_drop   = frame_done & w_full;
   assign w_rel_ok = host_release & ~w_empty;
   assign w_rel_uf = host_release & w_empty;

   assign w_rd_ptr_nxt = w_rel_ok ? (r_rd_ptr + C_IDX_ONE) : r_rd_ptr;
   assign w_cnt_nxt    = r_cnt + CNT_W'(w_wr_acc) - CNT_W'(w_rel_ok);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         r_drop_cnt <= '0;
         r_err_uf   <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + C_IDX_ONE;
         end
         r_rd_ptr <= w_rd_ptr_nxt;
         r_cnt    <= w_cnt_nxt;
         if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) begin
            r_drop_cnt <= r_drop_cnt + 32'd1;
         end
         if (w_rel_uf) begin
            r_err_uf <= 1'b1;
         end
      end
   end

   // The read port is addressed with the post-edge read pointer so rd_len
   // already shows the next slot in the cycle after a release.
   rx_slot_len_ram #(
      .DEPTH (SLOT_NUM),
      .WIDTH (LEN_W)
   ) u_len_ram (
      .clk     (sys_clk),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (frame_len),
      .i_raddr (w_rd_ptr_nxt),
      .o_rdata (w_rd_data)
   );

   assign rx_empty      = (r_cnt != C_FULL);
   assign rd_valid      = (r_cnt != '0);
   assign rd_len        = rd_valid ? w_rd_data : '0;
   assign slot_wr_idx   = r_wr_ptr;
   assign slot_rd_idx   = r_rd_ptr;
   assign pending_cnt   = r_cnt;
   assign drop_cnt      = r_drop_cnt;
   assign err_underflow = r_err_uf;

`ifdef RX_IRQ_COALESCE_EN
   localparam int               TMR_W      = idx_w(IRQ_TIMEOUT) + 1;
   localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(IRQ_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_THRESH   = CNT_W'(IRQ_THRESH);

   logic [IRQ_ST_W-1:0] r_irq_st;
   logic [IRQ_ST_W-1:0] w_irq_st_nxt;
   logic [TMR_W-1:0]    r_tmr;
   logic [TMR_W-1:0]    w_tmr_nxt;

   // Decisions use the post-edge occupancy so that a lone frame fires exactly
   // IRQ_TIMEOUT cycles after it is accepted.
   always_comb begin
      w_irq_st_nxt = r_irq_st;
      w_tmr_nxt    = '0;
      case (r_irq_st)
         IRQ_IDLE: begin
            if (w_cnt_nxt != '0) begin
               w_irq_st_nxt = IRQ_WAIT;
            end
         end
         IRQ_WAIT: begin
            if (w_cnt_nxt == '0) begin
               w_irq_st_nxt = IRQ_IDLE;
            end else if ((w_cnt_nxt >= C_THRESH) || (w_cnt_nxt == C_FULL) ||
                         (r_tmr == C_TMR_LAST)) begin
               w_irq_st_nxt = IRQ_FIRE;
            end else begin
               w_tmr_nxt = r_tmr + TMR_W'(1);
            end
         end
         IRQ_FIRE: begin
            if (w_cnt_nxt == '0) begin
               w_irq_st_nxt = IRQ_IDLE;
            end
         end
         default: begin
            w_irq_st_nxt = IRQ_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_irq_st <= IRQ_IDLE;
         r_tmr    <= '0;
      end else begin
         r_irq_st <= w_irq_st_nxt;
         r_tmr    <= w_tmr_nxt;
      end
   end

   assign irq = (r_irq_st == IRQ_FIRE);
`else
   logic r_irq;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= (w_cnt_nxt != '0);
      end
   end

   assign irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: doc/rx_slot_ctrl.md
Name: rx_slot_ctrl

Overview:
- Scheduler for the RX frame slot buffer written by the ethpipe RX path and drained by the host over PCI.
- Splits the slot memory into SLOT_NUM ring slots and owns the ring's write index, read index and occupancy count.
- Tells the RX writer whether a free slot exists, records each frame's length, and presents the oldest frame to the host until it is released.
- Raises an interrupt and counts frames dropped on overflow.

Parameters:
- SLOT_NUM, 4, number of ring slots; power of two, 2..16.
- LEN_W, 16, width of the frame length in bytes.
- IRQ_THRESH, 2, pending-frame count that fires the interrupt (coalescing build only).
- IRQ_TIMEOUT, 1024, cycles from first pending frame to forced interrupt (coalescing build only).

Ports:
- sys_clk  in  1  block clock; pci_clk domain.
- sys_rst_n  in  1  synchronous, active-low reset.
- frame_done  in  1  1-cycle pulse from the RX writer: frame fully written into slot slot_wr_idx.
- frame_len  in  LEN_W  byte length of the frame; valid with frame_done.
- host_release  in  1  1-cycle pulse from the host register write: slot slot_rd_idx is consumed.
- rx_empty  out  1  high = a free slot exists at slot_wr_idx; the writer may start a frame.
- slot_wr_idx  out  log2(SLOT_NUM)  slot currently owned by the RX writer; upper slot address bits.
- slot_rd_idx  out  log2(SLOT_NUM)  oldest filled slot, presented to the host.
- rd_valid  out  1  high = slot_rd_idx holds an unreleased frame.
- rd_len  out  LEN_W  length of the frame in slot_rd_idx; 0 when rd_valid=0.
- pending_cnt  out  log2(SLOT_NUM)+1  number of filled, unreleased slots.
- drop_cnt  out  32  frames lost because the ring was full; saturates at 0xFFFFFFFF.
- err_underflow  out  1  sticky: host_release arrived while rd_valid=0.
- irq  out  1  level interrupt to the PCI core.

Behaviour:
- Reset (sys_rst_n=0 at a sys_clk edge) clears the following:
  - wr_ptr, rd_ptr, pending_cnt, drop_cnt, err_underflow and irq all go to 0; the length RAM is not cleared.
  - Consequently rx_empty=1, rd_valid=0 and rd_len=0.
- rx_empty = (pending_cnt != SLOT_NUM). rd_valid = (pending_cnt != 0). Both are combinational from registered state.
- frame_done handling:
  - If pending_cnt < SLOT_NUM: len_ram[wr_ptr] <= frame_len; wr_ptr <= wr_ptr+1 (wraps mod SLOT_NUM); pending_cnt increments. The new slot becomes visible to the host one cycle after the pulse.
  - If pending_cnt == SLOT_NUM: drop_cnt increments (saturating); no other state changes.
- host_release handling:
  - If rd_valid: rd_ptr <= rd_ptr+1 (wraps); pending_cnt decrements; rd_len reflects the new slot the next cycle.
  - Else: ignored, and err_underflow <= 1. err_underflow clears only on reset.
- Simultaneous frame_done and host_release:
  - Each is evaluated against the pre-edge pending_cnt.
  - Not full and not empty: both pointers advance and pending_cnt is unchanged.
  - Full: the frame is dropped and the release is performed, so pending_cnt becomes SLOT_NUM-1.
  - Empty: the frame is accepted and the release is flagged as underflow, so pending_cnt becomes 1.
- rd_len is a registered read of len_ram[rd_ptr]. When the write and read targets are the same slot in the same cycle, the new frame_len is forwarded so that rd_len is correct one cycle after frame_done into an empty ring.
- Interrupt, base build: irq is registered; irq <= (next pending_cnt != 0), so it asserts one cycle after the first frame_done.
- Reset mid-operation discards all pending slots; the writer sees rx_empty=1 the cycle after reset is released.

Optional Feature:
- Macro: RX_IRQ_COALESCE_EN.
- Without the macro, irq follows the base rule above.
- With the macro, irq comes from a three-state FSM with a timer:
  - IDLE: irq=0, timer=0. Go to WAIT when pending_cnt becomes nonzero.
  - WAIT: timer increments each cycle. Go to FIRE when pending_cnt >= IRQ_THRESH, or timer == IRQ_TIMEOUT-1, or the ring is full. Go back to IDLE when pending_cnt returns to 0 before firing.
  - FIRE: irq=1. Go to IDLE when pending_cnt == 0.
- Reset places the FSM in IDLE.

Decomposition:
- Shared package ethpipe_pkg holds:
  - the slot count and index width derived from SLOT_NUM;
  - the LEN_W default;
  - the irq FSM state encoding (IDLE, WAIT, FIRE).
- One sub-module, rx_slot_len_ram: a SLOT_NUM x LEN_W register file with one write port, one registered read port and write-to-read forwarding.

Test Plan:
- Reset, then 3 frame_done pulses with lengths 64, 1518, 60 → pending_cnt=3, slot_wr_idx=3, rd_len=64; 3 releases return 1518, 60, then rd_valid=0.
- 6 frames into SLOT_NUM=4 with no release → rx_empty=0 after frame 4, drop_cnt=2, pending_cnt=4.
- Ring full, frame_done and host_release in the same cycle → drop_cnt increments, pending_cnt=3, rx_empty=1.
- host_release with the ring empty → err_underflow=1, pointers unchanged; a later reset clears it.
- Drive pointers through 9 frame/release pairs → slot_wr_idx and slot_rd_idx wrap 3→0 and each rd_len matches its frame.
- RX_IRQ_COALESCE_EN: one frame with no release → irq rises exactly IRQ_TIMEOUT cycles later; two back-to-back frames → irq in WAIT+1 cycle; draining all slots → irq=0.
